// File: rtl/freq_counter_pkg.sv
// Shared types and character codes for the frequency-counter display path.
package freq_counter_pkg;
  localparam logic [3:0] CHAR_BLANK   = 4'hF;
  localparam logic [3:0] CHAR_INVALID = 4'hE;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {IDLE, SEND} reader_state_t;
endpackage

// File: rtl/bcd_digit_reader_if.sv
// Character stream from the BCD reader to the OLED text renderer (valid/ready).
interface bcd_digit_reader_if;
  import freq_counter_pkg::*;

  logic       char_valid_out;
  logic       char_ready_in;
  bcd_digit_t char_code_out;
  logic       char_last_out;

  modport master (output char_valid_out, char_code_out, char_last_out,
                  input  char_ready_in);
  modport slave  (input  char_valid_out, char_code_out, char_last_out,
                  output char_ready_in);
endinterface

// File: rtl/bcd_digit_reader_blank_mask.sv
// Leading-zero blank vector: a digit is blanked when it and all higher digits
// are zero; digit 0 is never blanked and any non-zero code (incl. >9) stops blanking.
module bcd_blank_mask #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [DIGITS-1:0]   blank_out
);
  logic zero_run;

  always_comb begin
    blank_out = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (bcd_in[4*i +: 4] == 4'd0);
      blank_out[i] = zero_run & (i != 0);
    end
  end
endmodule

// File: rtl/bcd_digit_reader.sv
// Snapshots a packed BCD word on start and streams it MSD first, one code per handshake.
// Leading-zero blanking is built only when BCD_READER_LEADING_ZERO_BLANK_EN is defined.
module bcd_digit_reader
  import freq_counter_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                start_in,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy_out,
  output logic                error_out,
  bcd_digit_reader_if.master  char_if
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  reader_state_t      state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_dec;
  logic [4*DIGITS-1:0] snap_q;
  bcd_digit_t         code_q;
  logic               last_q;
  logic               error_q;
  logic               load, adv;
  bcd_digit_t         digit_first, digit_next;
  logic               blank_first, blank_next;

  function automatic bcd_digit_t char_code(input bcd_digit_t d, input logic blank);
    if (d > 4'd9) return CHAR_INVALID;
    if (blank)    return CHAR_BLANK;
    return d;
  endfunction

  assign idx_dec     = idx_q - IDX_W'(1);
  assign digit_first = bcd_in[4*(DIGITS-1) +: 4];
  assign digit_next  = snap_q[4*idx_dec +: 4];

`ifdef BCD_READER_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] mask_w, mask_q;

  bcd_blank_mask #(.DIGITS(DIGITS)) u_blank_mask (
    .bcd_in    (bcd_in),
    .blank_out (mask_w)
  );

  always_ff @(posedge clk_in) begin
    if (load) mask_q <= mask_w;
  end

  assign blank_first = mask_w[DIGITS-1];
  assign blank_next  = mask_q[idx_dec];
`else
  assign blank_first = 1'b0;
  assign blank_next  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (char_if.char_ready_in) begin
          if (idx_q == '0) state_d = IDLE;
          else             adv     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: control and registered character outputs
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      code_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        code_q  <= char_code(digit_first, blank_first);
        last_q  <= (DIGITS == 1);
        error_q <= 1'b0;
      end else begin
        if (adv) begin
          code_q <= char_code(digit_next, blank_next);
          last_q <= (idx_dec == '0);
        end
        // Flag lands the cycle after an invalid code is on the output.
        if (state_q == SEND && code_q == CHAR_INVALID) error_q <= 1'b1;
      end
    end
  end

  // Snapshot and digit index; state_q alone decides whether they are live
  always_ff @(posedge clk_in) begin
    if (load) begin
      snap_q <= bcd_in;
      idx_q  <= IDX_W'(DIGITS - 1);
    end else if (adv) begin
      idx_q  <= idx_dec;
    end
  end

  assign busy_out               = (state_q == SEND);
  assign error_out              = error_q;
  assign char_if.char_valid_out = (state_q == SEND);
  assign char_if.char_code_out  = code_q;
  assign char_if.char_last_out  = last_q;
endmodule

// File: tb/tb_bcd_digit_reader.sv
// Self-checking bench for bcd_digit_reader (DIGITS=4); honours BCD_READER_LEADING_ZERO_BLANK_EN.
module tb_bcd_digit_reader;
`ifdef BCD_READER_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd = '0;
  logic        busy, err;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  got_q[$];
  logic        got_last_q[$];
  bit          exp_err;

  bcd_digit_reader_if cif ();

  bcd_digit_reader #(.DIGITS(4)) dut (
    .clk_in    (clk),
    .reset_in  (rst),
    .start_in  (start),
    .bcd_in    (bcd),
    .busy_out  (busy),
    .error_out (err),
    .char_if   (cif)
  );

  always #5 clk = ~clk;

  // Expected character list from the digit rules, written with plain arithmetic.
  task automatic build_exp(input logic [15:0] v);
    int  d;
    bit  seen;
    exp_q.delete();
    exp_err = 1'b0;
    seen    = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = (int'(v) >> (4 * i)) & 15;
      if (d > 9) begin
        exp_q.push_back(4'hE);
        exp_err = 1'b1;
        seen    = 1'b1;
      end else if (BLANK_EN && !seen && d == 0 && i != 0) begin
        exp_q.push_back(4'hF);
      end else begin
        exp_q.push_back(4'(d));
        if (d != 0) seen = 1'b1;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the first edge with start sampled.
  task automatic do_start(input logic [15:0] v);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accept characters until the last one; returns one cycle after the final transfer.
  task automatic collect(input bit rnd, output bit timed_out);
    bit r;
    got_q.delete();
    got_last_q.delete();
    timed_out = 1'b1;
    for (int c = 0; c < 200; c++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cif.char_ready_in = r;
      if (cif.char_valid_out && r) begin
        got_q.push_back(cif.char_code_out);
        got_last_q.push_back(cif.char_last_out);
        if (cif.char_last_out) begin
          @(negedge clk);
          cif.char_ready_in = 1'b0;
          timed_out = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    cif.char_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cif.char_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (cif.char_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", cif.char_valid_out); end
    if (cif.char_code_out !== 4'h0) begin n_bad++; $display("FAIL reset_code got=%h want=0", cif.char_code_out); end
    if (cif.char_last_out !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b want=0", cif.char_last_out); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name, input logic [15:0] v);
    bit to;
    build_exp(v);
    do_start(v);
    n_cmp++;
    if (cif.char_valid_out !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL %s_first_valid got=%b/%b want=1/1", name, cif.char_valid_out, busy);
    end
    collect(1'b0, to);
    n_cmp++;
    if (to || got_q.size() != 4) begin
      n_bad++; $display("FAIL %s_count got=%0d timeout=%0b want=4", name, got_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL %s_code[%0d] got=%h want=%h", name, i, got_q[i], exp_q[i]); end
        n_cmp++;
        if (got_last_q[i] !== (i == 3)) begin n_bad++; $display("FAIL %s_last[%0d] got=%b want=%b", name, i, got_last_q[i], i == 3); end
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || cif.char_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL %s_busy_drop got=%b/%b want=0/0", name, busy, cif.char_valid_out);
    end
  endtask

  task automatic test_backpressure();
    bit         pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit         r, stalled;
    logic [3:0] held_code;
    logic       held_last;
    bit         done;
    build_exp(16'h1234);
    do_start(16'h1234);
    got_q.delete();
    stalled = 1'b0;
    done    = 1'b0;
    held_code = '0;
    held_last = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stalled) begin
        n_cmp++;
        if (cif.char_valid_out !== 1'b1 || cif.char_code_out !== held_code || cif.char_last_out !== held_last) begin
          n_bad++; $display("FAIL bp_stall c=%0d got=%b/%h/%b want=1/%h/%b", c, cif.char_valid_out,
                            cif.char_code_out, cif.char_last_out, held_code, held_last);
        end
      end
      r = (c < 7) ? pat[c] : 1'b1;
      cif.char_ready_in = r;
      stalled   = cif.char_valid_out && !r;
      held_code = cif.char_code_out;
      held_last = cif.char_last_out;
      if (cif.char_valid_out && r) begin
        got_q.push_back(cif.char_code_out);
        if (cif.char_last_out) done = 1'b1;
      end
      @(negedge clk);
    end
    cif.char_ready_in = 1'b0;
    n_cmp++;
    if (got_q.size() != 4) begin
      n_bad++; $display("FAIL bp_count got=%0d want=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_code[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_invalid();
    bit to;
    build_exp(16'h0A05);
    do_start(16'h0A05);
    collect(1'b0, to);
    n_cmp++;
    if (to || got_q.size() != 4) begin
      n_bad++; $display("FAIL inv_count got=%0d timeout=%0b want=4", got_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL inv_code[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
    end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err_set got=%b want=1", err); end
    do_start(16'h0001);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL inv_err_clear got=%b want=0", err); end
    build_exp(16'h0001);
    collect(1'b0, to);
    n_cmp++;
    if (to || got_q.size() != 4 || got_q[3] !== exp_q[3] || got_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL inv_next_stream size=%0d timeout=%0b", got_q.size(), to);
    end
  endtask

  task automatic test_busy_start();
    int n_tx;
    bit done;
    do_start(16'h9999);
    n_tx = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cif.char_ready_in = 1'b1;
      start = (c == 1) || (cif.char_last_out === 1'b1);
      bcd   = (c == 1) ? 16'h1111 : 16'($urandom);
      if (cif.char_valid_out) begin
        n_cmp++;
        if (cif.char_code_out !== 4'h9) begin n_bad++; $display("FAIL busy_code[%0d] got=%h want=9", n_tx, cif.char_code_out); end
        n_tx++;
        if (cif.char_last_out) done = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    cif.char_ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (cif.char_valid_out !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL busy_no_restart c=%0d got=%b/%b want=0/0", c, cif.char_valid_out, busy);
      end
      @(negedge clk);
    end
    cif.char_ready_in = 1'b0;
    n_cmp++;
    if (n_tx != 4) begin n_bad++; $display("FAIL busy_tx_count got=%0d want=4", n_tx); end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_start(16'h5678);
    cif.char_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (cif.char_valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b want=0", cif.char_valid_out); end
    if (cif.char_code_out !== 4'h0) begin n_bad++; $display("FAIL rmid_code got=%h want=0", cif.char_code_out); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got=%b want=0", err); end
    rst = 1'b0;
    cif.char_ready_in = 1'b0;
    @(negedge clk);
    test_basic("rmid_restart", 16'h0007);
    to = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] v;
    int          d;
    bit          to;
    for (int n = 0; n < 25; n++) begin
      v = '0;
      for (int i = 0; i < 4; i++) begin
        d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        if ($urandom_range(0, 2) == 0 && i >= 2) d = 0;
        v[4*i +: 4] = 4'(d);
      end
      build_exp(v);
      do_start(v);
      collect(1'b1, to);
      n_cmp++;
      if (to || got_q.size() != 4) begin
        n_bad++; $display("FAIL rnd_count v=%h got=%0d timeout=%0b want=4", v, got_q.size(), to);
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_cmp++;
          if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_code v=%h [%0d] got=%h want=%h", v, i, got_q[i], exp_q[i]); end
        end
      end
      n_cmp++;
      if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err v=%h got=%b want=%b", v, err, exp_err); end
      @(negedge clk);
    end
  endtask

  initial begin
    cif.char_ready_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic("basic", 16'h0042);
    test_basic("zero", 16'h0000);
    test_backpressure();
    test_invalid();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
